// File: rtl/or1200_pc_redirect_ctrl_if.sv
// Redirect handshake between the PC redirect controller and the fetch stage.
// The controller drives valid/addr/src, and fetch answers with ready.
interface or1200_pc_redirect_ctrl_if;
    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic [2:0]  src;

    modport master (output valid, output addr, output src, input ready);
    modport slave  (input valid, input addr, input src, output ready);
endinterface

// File: rtl/or1200_pc_redirect_ctrl.sv
// Arbitrates non-sequential fetch PC updates (debug, SPR NPC write, exception, branch/RFE)
// and holds the winning target in a valid/ready handshake until fetch takes it.
module or1200_pc_redirect_ctrl #(
    parameter logic [19:0] EPH0_P  = 20'h00000,
    parameter logic [19:0] EPH1_P  = 20'hF0000,
    parameter logic [7:0]  EXC_OFS = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        du_flush_pipe,
    input  logic [31:0] du_npc,
    input  logic        spr_pc_we,
    input  logic [31:0] spr_dat_i,
    input  logic        except_start,
    input  logic [3:0]  except_type,
    input  logic        except_prefix,
    input  logic [2:0]  branch_op,
    input  logic        flag,
    input  logic [29:0] ex_branch_addrtarget,
    input  logic [31:0] operand_b,
    input  logic [31:0] epcr,
    input  logic [2:0]  pre_branch_op,
    input  logic        lsu_stall,
    input  logic        genpc_refetch,
    or1200_pc_redirect_ctrl_if.master redir,
    output logic        ex_branch_taken,
    output logic        branch_busy,
    output logic        wait_lsu,
    output logic        genpc_refetch_r
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_LSUW = 2'd2
    } state_t;

    localparam logic [2:0] SRC_NONE = 3'd0;
    localparam logic [2:0] SRC_DU   = 3'd1;
    localparam logic [2:0] SRC_SPR  = 3'd2;
    localparam logic [2:0] SRC_EXC  = 3'd3;
    localparam logic [2:0] SRC_BR   = 3'd4;
    localparam logic [2:0] SRC_RFE  = 3'd5;

    // Larger rank wins; branch and RFE share the lowest live rank.
    function automatic logic [2:0] src_rank(input logic [2:0] src);
        logic [2:0] rank;
        case (src)
            SRC_DU:  rank = 3'd4;
            SRC_SPR: rank = 3'd3;
            SRC_EXC: rank = 3'd2;
            SRC_BR:  rank = 3'd1;
            SRC_RFE: rank = 3'd1;
            default: rank = 3'd0;
        endcase
        return rank;
    endfunction

    state_t      state_r, state_n_s;
    logic [31:0] addr_r;
    logic [2:0]  src_r;
    logic        valid_r, busy_r, taken_r, wait_lsu_r, refetch_r;
    logic [2:0]  req_src_s;
    logic [31:0] req_addr_s;
    logic        cap_s;

    // Decode the single winning request of this cycle and its target address.
    always_comb begin
        req_src_s  = SRC_NONE;
        req_addr_s = 32'h0000_0000;
        if (du_flush_pipe) begin
            req_src_s  = SRC_DU;
            req_addr_s = du_npc;
        end else if (spr_pc_we) begin
            req_src_s  = SRC_SPR;
            req_addr_s = spr_dat_i;
        end else if (except_start) begin
            req_src_s  = SRC_EXC;
            req_addr_s = {(except_prefix ? EPH1_P : EPH0_P), except_type, EXC_OFS};
        end else begin
            case (branch_op)
                3'd1, 3'd3: begin
                    req_src_s  = SRC_BR;
                    req_addr_s = {ex_branch_addrtarget, 2'b00};
                end
                3'd2: begin
                    req_src_s  = SRC_BR;
                    req_addr_s = operand_b;
                end
                3'd4, 3'd5: begin
                    // BF takes on flag set, BNF on flag clear.
                    if (flag == (branch_op == 3'd4)) begin
                        req_src_s  = SRC_BR;
                        req_addr_s = {ex_branch_addrtarget, 2'b00};
                    end else begin
                        req_src_s  = SRC_NONE;
                    end
                end
                3'd6: begin
                    req_src_s  = SRC_RFE;
                    req_addr_s = epcr;
                end
                default: req_src_s = SRC_NONE;
            endcase
        end
    end

    // Next-state and capture decision.
    always_comb begin
        state_n_s = state_r;
        cap_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_src_s != SRC_NONE) begin
                    cap_s     = 1'b1;
                    state_n_s = (src_rank(req_src_s) == 3'd1 && lsu_stall) ? ST_LSUW : ST_PEND;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (redir.ready) begin
                    cap_s     = (req_src_s != SRC_NONE);
                    state_n_s = (req_src_s != SRC_NONE) ? ST_PEND : ST_IDLE;
                end else if (src_rank(req_src_s) > src_rank(src_r)) begin
                    cap_s = 1'b1;
                end else begin
                    cap_s = 1'b0;
                end
            end
            ST_LSUW: begin
                // Only DU/SPR/EXC may displace a branch parked behind the LSU.
                if (src_rank(req_src_s) >= 3'd2) begin
                    cap_s     = 1'b1;
                    state_n_s = ST_PEND;
                end else if (!lsu_stall) begin
                    state_n_s = ST_PEND;
                end else begin
                    state_n_s = ST_LSUW;
                end
            end
            default: state_n_s = ST_IDLE;
        endcase
    end

    // State, captured redirect and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            addr_r  <= 32'h0000_0000;
            src_r   <= SRC_NONE;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            taken_r <= 1'b0;
        end else begin
            state_r <= state_n_s;
            valid_r <= (state_n_s == ST_PEND);
            busy_r  <= (state_n_s != ST_IDLE);
            taken_r <= cap_s && (src_rank(req_src_s) <= 3'd2);
            if (cap_s) begin
                addr_r <= req_addr_s;
                src_r  <= req_src_s;
            end else if (state_n_s == ST_IDLE) begin
                src_r  <= SRC_NONE;
            end
        end
    end

    // LSU-wait flag for ID-stage branches and the delayed refetch request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_lsu_r <= 1'b0;
            refetch_r  <= 1'b0;
        end else begin
            refetch_r <= genpc_refetch;
            if (!wait_lsu_r && (pre_branch_op != 3'd0) && lsu_stall) begin
                wait_lsu_r <= 1'b1;
            end else if (pre_branch_op == 3'd0) begin
                wait_lsu_r <= 1'b0;
            end
        end
    end

    assign redir.valid     = valid_r;
    assign redir.addr      = addr_r;
    assign redir.src       = src_r;
    assign ex_branch_taken = taken_r;
    assign branch_busy     = busy_r;
    assign wait_lsu        = wait_lsu_r;
    assign genpc_refetch_r = refetch_r;

endmodule
